// File: rtl/rfin_packet_demod.sv
// OOK RF pulse demodulator: preamble lock, cell windowing, 64-bit framing.
// In: i_PCLK, i_RST, i_RX, i_RFIN. Out: o_PKT_DATA, o_PKT_REC, o_SYNC_ERR, o_LOCK.
module rfin_packet_demod #(
  parameter int BIT_PERIOD   = 10000,
  parameter int TOL          = 2500,
  parameter int PREAMBLE_LEN = 8,
  parameter int PKT_BITS     = 64,
  parameter int CNT_W        = 16
) (
  input  logic                i_PCLK,
  input  logic                i_RST,
  input  logic                i_RX,
  input  logic                i_RFIN,
  output logic [PKT_BITS-1:0] o_PKT_DATA,
  output logic                o_PKT_REC,
  output logic                o_SYNC_ERR,
  output logic                o_LOCK
);

  localparam int PC_W = $clog2(PREAMBLE_LEN + 1);
  localparam int BC_W = $clog2(PKT_BITS + 1);

  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(BIT_PERIOD - TOL);
  localparam logic [CNT_W-1:0] WIN_HI = CNT_W'(BIT_PERIOD + TOL);
  localparam logic [CNT_W-1:0] ZERO_LD = CNT_W'(TOL + 1);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PREAMBLE_LEN - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PKT_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    PREAMBLE,
    DATA,
    DONE
  } state_t;

  state_t state, state_d;

  logic rf_s1, rf_s2, rf_s3, pulse;

  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc;
  logic [PC_W-1:0] pcnt, pcnt_d;
  logic [BC_W-1:0] bcnt, bcnt_d;
  logic [PKT_BITS-1:0] sreg, sreg_d, shifted;
  logic [PKT_BITS-1:0] data_d;
  logic rec_d, err_d;
  logic early, tmo;

  always_ff @(posedge i_PCLK) begin
    if (i_RST) begin
      rf_s1      <= 1'b0;
      rf_s2      <= 1'b0;
      rf_s3      <= 1'b0;
      pulse      <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      pcnt       <= '0;
      bcnt       <= '0;
      sreg       <= '0;
      o_PKT_DATA <= '0;
      o_PKT_REC  <= 1'b0;
      o_SYNC_ERR <= 1'b0;
    end else begin
      rf_s1      <= i_RFIN;
      rf_s2      <= rf_s1;
      rf_s3      <= rf_s2;
      pulse      <= rf_s2 & ~rf_s3;
      state      <= state_d;
      cnt        <= cnt_d;
      pcnt       <= pcnt_d;
      bcnt       <= bcnt_d;
      sreg       <= sreg_d;
      o_PKT_DATA <= data_d;
      o_PKT_REC  <= rec_d;
      o_SYNC_ERR <= err_d;
    end
  end

  assign early   = cnt < WIN_LO;
  assign tmo     = cnt == WIN_HI;
  assign cnt_inc = tmo ? cnt : cnt + 1'b1;
  assign shifted = {sreg[PKT_BITS-2:0], pulse};

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pcnt_d  = pcnt;
    bcnt_d  = bcnt;
    sreg_d  = sreg;
    data_d  = o_PKT_DATA;
    rec_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (i_RX) state_d = HUNT;
      end
      HUNT: begin
        cnt_d = '0;
        if (pulse) begin
          state_d = PREAMBLE;
          pcnt_d  = PC_W'(1);
          cnt_d   = CNT_W'(1);
        end
      end
      PREAMBLE: begin
        cnt_d = cnt_inc;
        if (pulse && early) begin
          pcnt_d = PC_W'(1);
          cnt_d  = CNT_W'(1);
        end else if (pulse) begin
          cnt_d = CNT_W'(1);
          if (pcnt == PC_LAST) begin
            state_d = DATA;
            bcnt_d  = '0;
            sreg_d  = '0;
          end else begin
            pcnt_d = pcnt + 1'b1;
          end
        end else if (tmo) begin
          state_d = HUNT;
        end
      end
      DATA: begin
        cnt_d = cnt_inc;
        if (pulse && early) begin
          // early pulse doubles as the first cell of a new preamble
          err_d   = 1'b1;
          state_d = PREAMBLE;
          pcnt_d  = PC_W'(1);
          cnt_d   = CNT_W'(1);
        end else if (pulse || tmo) begin
          // a zero re-anchors on the virtual mid-cell, TOL cycles back
          sreg_d = shifted;
          bcnt_d = bcnt + 1'b1;
          cnt_d  = pulse ? CNT_W'(1) : ZERO_LD;
          if (bcnt == BC_LAST) begin
            data_d  = shifted;
            rec_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = HUNT;
      end
      default: state_d = IDLE;
    endcase
    if (!i_RX) begin
      state_d = IDLE;
      data_d  = o_PKT_DATA;
      rec_d   = 1'b0;
      err_d   = 1'b0;
    end
  end

  assign o_LOCK = (state == DATA);

endmodule

// File: tb/tb_rfin_packet_demod.sv
// Scoreboard bench for rfin_packet_demod.
// Directed packets; a monitor pops expected payloads on o_PKT_REC.
module tb_rfin_packet_demod;

  localparam int BP  = 50;
  localparam int TL  = 10;
  localparam int JIT = 7;
  // last preamble pulse start to strobe for an all-zero payload:
  // 3 sync/detect + 1 accept + (BP+TL-1) to first timeout + 1,
  // then 63 more cells of BP each
  localparam int ZERO_LAT = 3214;

  logic clk = 1'b0;
  logic rst, rx, rfin;
  logic [63:0] pkt_data;
  logic pkt_rec, sync_err, lock;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc      = 0;
  int se_cnt   = 0;
  int last_pulse_cyc = 0;
  int rec_cyc  = 0;
  logic [63:0] exp_q[$];

  logic [63:0] b2b[10] = '{
    64'h0000000000000001, 64'hFFFFFFFFFFFFFFFF,
    64'h8000000000000000, 64'hAAAAAAAAAAAAAAAA,
    64'h5555555555555555, 64'h0123456789ABCDEF,
    64'hFEDCBA9876543210, 64'h00FF00FF00FF00FF,
    64'hC3C3C3C3A5A5A5A5, 64'h7FFFFFFFFFFFFFFE
  };

  rfin_packet_demod #(
    .BIT_PERIOD(BP),
    .TOL(TL),
    .PREAMBLE_LEN(8),
    .PKT_BITS(64),
    .CNT_W(8)
  ) dut (
    .i_PCLK(clk),
    .i_RST(rst),
    .i_RX(rx),
    .i_RFIN(rfin),
    .o_PKT_DATA(pkt_data),
    .o_PKT_REC(pkt_rec),
    .o_SYNC_ERR(sync_err),
    .o_LOCK(lock)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // monitor: scoreboard pop on every packet strobe
  always @(negedge clk) begin
    if (sync_err) se_cnt++;
    if (pkt_rec) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_rec: got %h expected none", pkt_data);
      end else begin
        check("pkt_data", pkt_data, exp_q.pop_front());
      end
    end
  end

  // pulse 2 cycles wide, next pulse starts g cycles after this one
  task automatic pulse_in(input int g);
    last_pulse_cyc = cyc;
    rfin = 1'b1;
    repeat (2) @(negedge clk);
    rfin = 1'b0;
    repeat (g - 2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // abort: -1 none, else data bit index; kind 1 = drop i_RX, 2 = reset
  task automatic send_pkt(input logic [63:0] d, input bit jit,
                          input int abort, input int kind);
    logic [71:0] b;
    int i, j, g;
    b = {8'hFF, d};
    i = 0;
    forever begin
      j = i + 1;
      while (j < 72 && !b[71-j]) j++;
      if (abort >= 0 && j > 8 + abort) begin
        pulse_in(BP * (8 + abort - i) + BP / 2);
        check("lock_mid", 64'(lock), 64'd1);
        if (kind == 1) rx = 1'b0;
        else rst = 1'b1;
        idle(2);
        rx  = 1'b1;
        rst = 1'b0;
        return;
      end
      if (j == 72) begin
        pulse_in(2);
        return;
      end
      g = BP * (j - i);
      if (jit) g = g + int'($urandom_range(2 * JIT)) - JIT;
      pulse_in(g);
      i = j;
    end
  endtask

  task automatic wait_rec(input string nm);
    int n;
    n = 0;
    while (!pkt_rec && n < 72 * BP + 300) begin
      @(negedge clk);
      n++;
    end
    chk_cnt++;
    if (pkt_rec) begin
      pass_cnt++;
      rec_cyc = cyc;
    end else begin
      $display("FAIL %s: got no o_PKT_REC expected strobe", nm);
    end
    @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    rx   = 1'b0;
    rfin = 1'b0;
    idle(3);
    check("rst_data", pkt_data, 64'h0);
    check("rst_rec", 64'(pkt_rec), 64'd0);
    check("rst_err", 64'(sync_err), 64'd0);
    check("rst_lock", 64'(lock), 64'd0);
    rst = 1'b0;
    rx  = 1'b1;
    idle(5);

    // clean packet
    exp_q.push_back(64'h8123456789ABCD0F);
    send_pkt(64'h8123456789ABCD0F, 1'b0, -1, 0);
    wait_rec("clean_rec");
    check("clean_no_err", 64'(se_cnt), 64'd0);
    check("clean_unlock", 64'(lock), 64'd0);
    idle(20);

    // all-zero payload: 64 timeouts, strobe latency fixed
    exp_q.push_back(64'h0);
    send_pkt(64'h0, 1'b0, -1, 0);
    wait_rec("zero_rec");
    check("zero_lat", 64'(rec_cyc - last_pulse_cyc), 64'(ZERO_LAT));
    idle(20);

    // jittered intervals
    exp_q.push_back(64'hF0E1D2C3B4A59687);
    send_pkt(64'hF0E1D2C3B4A59687, 1'b1, -1, 0);
    wait_rec("jit_rec");
    idle(20);

    // early pulse during data: sync error, no packet
    for (int k = 1; k <= 12; k++) pulse_in(k == 12 ? BP - 13 : BP);
    pulse_in(2);
    idle(4 * BP);
    check("early_err", 64'(se_cnt), 64'd1);
    check("early_unlock", 64'(lock), 64'd0);

    // broken preamble, then good packet
    for (int k = 0; k < 3; k++) pulse_in(BP);
    idle(4 * BP);
    check("brk_unlock", 64'(lock), 64'd0);
    exp_q.push_back(64'hFFFF0000A5A5C3C3);
    send_pkt(64'hFFFF0000A5A5C3C3, 1'b0, -1, 0);
    wait_rec("brk_rec");
    idle(20);

    // receive disabled mid-packet
    send_pkt(64'h123456789ABCDEF0, 1'b0, 30, 1);
    check("rx_unlock", 64'(lock), 64'd0);
    check("rx_keep", pkt_data, 64'hFFFF0000A5A5C3C3);
    idle(4 * BP);

    // reset mid-packet
    send_pkt(64'h123456789ABCDEF0, 1'b0, 30, 2);
    check("rst_unlock", 64'(lock), 64'd0);
    check("rst_clear", pkt_data, 64'h0);
    idle(4 * BP);

    // back-to-back
    for (int k = 0; k < 10; k++) begin
      exp_q.push_back(b2b[k]);
      send_pkt(b2b[k], 1'b0, -1, 0);
      wait_rec("b2b_rec");
      idle(7);
    end
    idle(20);

    check("q_empty", 64'(exp_q.size()), 64'd0);
    check("final_err", 64'(se_cnt), 64'd1);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
